sdram_arbiter: RTL

Central sequencer for the SDRAM command/address bus. It holds the bus for the power-up init block until that block finishes. After that it owns an internal auto-refresh interval timer and grants the bus to exactly one of three sub-blocks: auto-refresh, write burst or read burst. It multiplexes the granted sub-block's 4-bit command {cs_n,ras_n,cas_n,we_n} and 12-bit address onto the SDRAM pins, and flags missed refreshes and hung sub-blocks.

---
 rtl/sdram_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_arbiter                                                            |
// | Sequences the SDRAM command/address bus: init, then refresh/write/read.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sdram_arbiter #(
   parameter int CNT_REF  = 749,
   parameter int MAX_BUSY = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  init_cmd,
   input  logic [11:0] init_addr,
   input  logic        init_end,
   input  logic [3:0]  aref_cmd,
   input  logic [11:0] aref_addr,
   input  logic        aref_end,
   input  logic        wr_req,
   input  logic [3:0]  wr_cmd,
   input  logic [11:0] wr_addr,
   input  logic        wr_end,
   input  logic        rd_req,
   input  logic [3:0]  rd_cmd,
   input  logic [11:0] rd_addr,
   input  logic        rd_end,
   output logic        aref_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic [3:0]  sdram_cmd,
   output logic [11:0] sdram_addr,
   output logic        ref_miss,
   output logic        err_timeout
);

   localparam int c_BW = $clog2(MAX_BUSY + 1);

   localparam logic [2:0] c_INIT  = 3'd0;
   localparam logic [2:0] c_ARBIT = 3'd1;
   localparam logic [2:0] c_AREF  = 3'd2;
   localparam logic [2:0] c_WRITE = 3'd3;
   localparam logic [2:0] c_READ  = 3'd4;

   localparam logic [3:0]      c_NOP       = 4'b0111;
   localparam logic            c_OP_WR     = 1'b0;
   localparam logic            c_OP_RD     = 1'b1;
   localparam logic [9:0]      c_REF_LAST  = 10'(CNT_REF);
   localparam logic [c_BW-1:0] c_BUSY_LAST = c_BW'(MAX_BUSY - 1);

   logic [2:0]      r_state;
   logic [9:0]      r_timer;
   logic [c_BW-1:0] r_busy;
   logic            r_ref_pend;
   logic            r_last_op;
   logic            r_ref_miss;
   logic            r_err_timeout;

   logic [2:0]      w_state_nxt;
   logic            w_timeout;
   logic            w_wrap;
   logic            w_busy_max;
   logic            w_op_state;

   assign w_op_state = (r_state == c_AREF) || (r_state == c_WRITE) || (r_state == c_READ);
   assign w_busy_max = (r_busy == c_BUSY_LAST);
   assign w_wrap     = (r_state != c_INIT) && (r_timer == c_REF_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      case (r_state)
         c_INIT: begin
            if (init_end) w_state_nxt = c_ARBIT;
         end
         c_ARBIT: begin
            if (r_ref_pend)          w_state_nxt = c_AREF;
            else if (wr_req && rd_req)
               w_state_nxt = (r_last_op == c_OP_RD) ? c_WRITE : c_READ;
            else if (wr_req)         w_state_nxt = c_WRITE;
            else if (rd_req)         w_state_nxt = c_READ;
         end
         c_AREF: begin
            if (aref_end)            w_state_nxt = c_ARBIT;
            else if (w_busy_max) begin
               w_state_nxt = c_ARBIT;
               w_timeout   = 1'b1;
            end
         end
         c_WRITE: begin
            if (wr_end)              w_state_nxt = c_ARBIT;
            else if (w_busy_max) begin
               w_state_nxt = c_ARBIT;
               w_timeout   = 1'b1;
            end
         end
         c_READ: begin
            if (rd_end)              w_state_nxt = c_ARBIT;
            else if (w_busy_max) begin
               w_state_nxt = c_ARBIT;
               w_timeout   = 1'b1;
            end
         end
         default: w_state_nxt = c_INIT;
      endcase
   end

   // The timer ticks on the edge leaving INIT so the first ARBIT cycle is count 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= c_INIT;
         r_timer       <= 10'd0;
         r_busy        <= '0;
         r_ref_pend    <= 1'b0;
         r_last_op     <= c_OP_RD;
         r_ref_miss    <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if ((r_state == c_INIT) && !init_end) r_timer <= 10'd0;
         else if (w_wrap)                      r_timer <= 10'd0;
         else                                  r_timer <= r_timer + 10'd1;

         if (w_op_state) r_busy <= r_busy + 1'b1;
         else            r_busy <= '0;

         // A wrap on the same edge as AREF entry keeps the new request pending.
         if (w_wrap) begin
            r_ref_pend <= 1'b1;
            if (r_ref_pend) r_ref_miss <= 1'b1;
         end else if ((r_state == c_ARBIT) && (w_state_nxt == c_AREF)) begin
            r_ref_pend <= 1'b0;
         end

         if (r_state == c_ARBIT) begin
            if (w_state_nxt == c_WRITE) r_last_op <= c_OP_WR;
            if (w_state_nxt == c_READ)  r_last_op <= c_OP_RD;
         end

         if (w_timeout) r_err_timeout <= 1'b1;
      end
   end

   assign aref_en     = (r_state == c_AREF);
   assign wr_en       = (r_state == c_WRITE);
   assign rd_en       = (r_state == c_READ);
   assign ref_miss    = r_ref_miss;
   assign err_timeout = r_err_timeout;

   always_comb begin
      sdram_cmd  = c_NOP;
      sdram_addr = 12'h000;
      case (r_state)
         c_INIT: begin
            sdram_cmd  = init_cmd;
            sdram_addr = init_addr;
         end
         c_AREF: begin
            sdram_cmd  = aref_cmd;
            sdram_addr = aref_addr;
         end
         c_WRITE: begin
            sdram_cmd  = wr_cmd;
            sdram_addr = wr_addr;
         end
         c_READ: begin
            sdram_cmd  = rd_cmd;
            sdram_addr = rd_addr;
         end
         default: begin
            sdram_cmd  = c_NOP;
            sdram_addr = 12'h000;
         end
      endcase
   end

endmodule
`default_nettype wire
